// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, 2-deep fetch buffer.
// A redirect during an outstanding request drains the stale word before refetching.
module if_fetch_unit #(
    parameter int              PC_W     = 12,
    parameter int              INS_W    = 19,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NW,
    input  logic             Redirect,
    input  logic [PC_W-1:0]  RedirectPC,
    output logic             ImemReq,
    output logic [PC_W-1:0]  ImemAddr,
    input  logic             ImemAck,
    input  logic [INS_W-1:0] ImemData,
    output logic             InsValid,
    output logic [INS_W-1:0] InsOut,
    output logic [PC_W-1:0]  PCout
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   drain_addr_q, drain_addr_d;
    logic [1:0]        count_q, count_d;
    logic [INS_W-1:0]  ins0_q, ins0_d, ins1_q, ins1_d;
    logic [PC_W-1:0]   nxt0_q, nxt0_d, nxt1_q, nxt1_d;

    logic              pop;
    logic              push;
    logic              wr_hi;
    logic [PC_W-1:0]   pc_inc;

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        ImemReq  = 1'b0;
        ImemAddr = pc_q;
        if (rst) begin
            ImemAddr = RESET_PC;
        end else begin
            unique case (state_q)
                RUN: ImemReq = (count_q != 2'd2);
                DRAIN: begin
                    ImemReq  = 1'b1;
                    ImemAddr = drain_addr_q;
                end
                default: ImemReq = 1'b0;
            endcase
        end
    end

    assign InsValid = ~rst & (state_q == RUN) & (count_q != 2'd0);
    assign InsOut   = InsValid ? ins0_q : '0;
    assign PCout    = InsValid ? nxt0_q : '0;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        ins0_d       = ins0_q;
        ins1_d       = ins1_q;
        nxt0_d       = nxt0_q;
        nxt1_d       = nxt1_q;
        pop          = InsValid & ~NW & ~Redirect;
        push         = 1'b0;
        wr_hi        = 1'b0;

        unique case (state_q)
            RUN: begin
                if (Redirect) begin
                    count_d = 2'd0;
                    pc_d    = RedirectPC;
                    if (ImemReq && !ImemAck) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else begin
                    push = ImemReq & ImemAck;
                    // Push lands behind the head unless the head leaves this edge.
                    wr_hi = (count_q == 2'd1) & ~pop;
                    if (pop) begin
                        ins0_d  = ins1_q;
                        nxt0_d  = nxt1_q;
                        count_d = count_q - 2'd1;
                    end
                    if (push) begin
                        pc_d = pc_inc;
                        if (wr_hi) begin
                            ins1_d = ImemData;
                            nxt1_d = pc_inc;
                        end else begin
                            ins0_d = ImemData;
                            nxt0_d = pc_inc;
                        end
                        count_d = pop ? count_q : count_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (Redirect) begin
                    pc_d = RedirectPC;
                end
                if (ImemAck) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= 2'd0;
            ins0_q       <= '0;
            ins1_q       <= '0;
            nxt0_q       <= '0;
            nxt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            ins0_q       <= ins0_d;
            ins1_q       <= ins1_d;
            nxt0_q       <= nxt0_d;
            nxt1_q       <= nxt1_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic,
// checked every cycle against a queue-based fetch model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        NW;
    logic        Redirect;
    logic [11:0] RedirectPC;
    logic        ImemReq;
    logic [11:0] ImemAddr;
    logic        ImemAck;
    logic [18:0] ImemData;
    logic        InsValid;
    logic [18:0] InsOut;
    logic [11:0] PCout;

    if_fetch_unit #(
        .PC_W(12),
        .INS_W(19),
        .RESET_PC(12'h000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .NW(NW),
        .Redirect(Redirect),
        .RedirectPC(RedirectPC),
        .ImemReq(ImemReq),
        .ImemAddr(ImemAddr),
        .ImemAck(ImemAck),
        .ImemData(ImemData),
        .InsValid(InsValid),
        .InsOut(InsOut),
        .PCout(PCout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] ins;
        logic [11:0] pcp1;
    } ent_t;

    int total = 0;
    int bad   = 0;

    ent_t        q[$];
    logic [11:0] m_pc    = 12'h000;
    logic        m_drain = 1'b0;
    logic [11:0] m_daddr = 12'h000;

    int mem_cnt   = 0;
    int mem_wait  = 0;
    bit rand_wait = 0;
    bit spurious  = 0;

    logic        obs_req, obs_valid, obs_ack;
    logic [11:0] obs_addr, obs_pc;
    logic [18:0] obs_ins;

    function automatic logic [18:0] mem_word(input logic [11:0] a);
        return {a[6:0], a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic nw, input logic rd,
                        input logic [11:0] rpc);
        logic        e_req, e_valid, acked, pop;
        logic [11:0] e_addr, e_pc;
        logic [18:0] e_ins;
        ent_t        e;
        @(negedge clk);
        rst        = r;
        NW         = nw;
        Redirect   = rd;
        RedirectPC = rpc;
        #1;
        if (ImemReq && mem_cnt >= mem_wait) begin
            ImemAck  = 1'b1;
            ImemData = mem_word(ImemAddr);
        end else begin
            ImemAck  = (!ImemReq && spurious) ? ($urandom_range(0, 3) == 0) : 1'b0;
            ImemData = 19'($urandom);
        end
        #1;
        e_req   = r ? 1'b0 : (m_drain ? 1'b1 : (q.size() < 2));
        e_addr  = r ? 12'h000 : (m_drain ? m_daddr : m_pc);
        e_valid = !r && !m_drain && q.size() > 0;
        e_ins   = e_valid ? q[0].ins : 19'h0;
        e_pc    = e_valid ? q[0].pcp1 : 12'h000;
        obs_req   = ImemReq;
        obs_addr  = ImemAddr;
        obs_ack   = ImemAck;
        obs_valid = InsValid;
        obs_ins   = InsOut;
        obs_pc    = PCout;
        chk("req", 32'(obs_req), 32'(e_req));
        chk("addr", 32'(obs_addr), 32'(e_addr));
        chk("valid", 32'(obs_valid), 32'(e_valid));
        chk("insout", 32'(obs_ins), 32'(e_ins));
        chk("pcout", 32'(obs_pc), 32'(e_pc));
        @(posedge clk);
        if (r) begin
            m_pc    = 12'h000;
            m_drain = 1'b0;
            q.delete();
        end else begin
            acked = e_req && obs_ack;
            pop   = e_valid && !nw && !rd;
            if (m_drain) begin
                if (rd) m_pc = rpc;
                if (acked) m_drain = 1'b0;
            end else if (rd) begin
                q.delete();
                if (e_req && !obs_ack) begin
                    m_drain = 1'b1;
                    m_daddr = m_pc;
                end
                m_pc = rpc;
            end else begin
                if (pop) void'(q.pop_front());
                if (acked) begin
                    e.ins  = mem_word(m_pc);
                    e.pcp1 = m_pc + 12'd1;
                    q.push_back(e);
                    m_pc = m_pc + 12'd1;
                end
            end
        end
        if (r) begin
            mem_cnt = 0;
        end else if (obs_req && obs_ack) begin
            mem_cnt = 0;
            if (rand_wait) mem_wait = $urandom_range(0, 3);
        end else if (obs_req) begin
            mem_cnt++;
        end
    endtask

    initial begin
        bit found;
        rst        = 1'b1;
        NW         = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 12'h000;
        ImemAck    = 1'b0;
        ImemData   = 19'h0;

        // reset and zero-wait streaming
        step(1, 0, 0, 0);
        chk("rst_req", 32'(obs_req), 0);
        chk("rst_valid", 32'(obs_valid), 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s1_addr0", 32'(obs_addr), 0);
        chk("s1_novalid", 32'(obs_valid), 0);
        step(0, 0, 0, 0);
        chk("s1_addr1", 32'(obs_addr), 1);
        chk("s1_pc1", 32'(obs_pc), 1);
        chk("s1_ins0", 32'(obs_ins), 0);
        step(0, 0, 0, 0);
        chk("s1_pc2", 32'(obs_pc), 2);
        chk("s1_ins1", 32'(obs_ins), 32'(mem_word(12'h001)));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // hold: buffer fills, request drops, no word lost
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("s2_req_drop", 32'(obs_req), 0);
        chk("s2_held", 32'(obs_valid), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // redirect while waiting on addr 5
        step(1, 0, 0, 0);
        mem_wait = 3;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(0, 0, 0, 0);
            if (obs_req && obs_addr == 12'h005) found = 1;
        end
        chk("s3_find5", 32'(found), 1);
        step(0, 0, 1, 12'h100);
        chk("s3_redir_addr", 32'(obs_addr), 5);
        step(0, 0, 0, 0);
        chk("s3_drain_addr", 32'(obs_addr), 5);
        chk("s3_drain_req", 32'(obs_req), 1);
        chk("s3_drain_valid", 32'(obs_valid), 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 0, 0);
            if (obs_valid) found = 1;
        end
        chk("s3_resume", 32'(found), 1);
        chk("s3_pc", 32'(obs_pc), 12'h101);
        chk("s3_ins", 32'(obs_ins), 32'(mem_word(12'h100)));

        // redirect in the ack cycle of addr 7
        step(1, 0, 0, 0);
        mem_wait = 0;
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 12'h100);
        chk("s4_addr7", 32'(obs_addr), 7);
        step(0, 0, 0, 0);
        chk("s4_addr100", 32'(obs_addr), 12'h100);
        chk("s4_dropped", 32'(obs_valid), 0);
        step(0, 0, 0, 0);
        chk("s4_pc", 32'(obs_pc), 12'h101);

        // PC wrap
        step(0, 0, 1, 12'hFFF);
        step(0, 0, 0, 0);
        chk("s5_addrfff", 32'(obs_addr), 12'hFFF);
        step(0, 0, 0, 0);
        chk("s5_addr000", 32'(obs_addr), 0);
        chk("s5_pcwrap", 32'(obs_pc), 0);
        chk("s5_insfff", 32'(obs_ins), 32'(mem_word(12'hFFF)));
        step(0, 0, 0, 0);
        chk("s5_pc001", 32'(obs_pc), 1);

        // reset in the middle of a drain
        step(1, 0, 0, 0);
        mem_wait = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 12'h200);
        step(1, 0, 0, 0);
        chk("s6_rst_req", 32'(obs_req), 0);
        chk("s6_rst_valid", 32'(obs_valid), 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s6_addr", 32'(obs_addr), 0);
        chk("s6_req", 32'(obs_req), 1);

        // random traffic
        rand_wait = 1;
        spurious  = 1;
        mem_wait  = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, nw, rd;
            logic [11:0] rpc;
            r   = ($urandom_range(0, 149) == 0);
            nw  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 2))
                                              : 12'($urandom);
            step(r, nw, rd, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
